// File: rtl/resp_analyzer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | resp_analyzer                                                          |
// | Dual-MISR output response analyzer grading one fault per session.      |
// | Optional feature macro: RA_DIRECT_CMP_EN (per-transfer direct compare).|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module resp_analyzer #(
  parameter int                  OUT_BITS   = 32,
  parameter int                  PAT_COUNT  = 256,
  parameter int                  NUM_FAULTS = 64,
  parameter logic [OUT_BITS-1:0] POLY       = OUT_BITS'(32'h8020_0003)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              pat_valid,
  output logic                              pat_ready,
  input  logic [OUT_BITS-1:0]               CUT_OP,
  input  logic [OUT_BITS-1:0]               FF_OP,
  output logic                              FIL_INC,
  output logic                              busy,
  output logic                              done,
  output logic                              det_valid,
  output logic                              det_flag,
  output logic [$clog2(NUM_FAULTS+1)-1:0]   fault_idx,
  output logic [$clog2(NUM_FAULTS+1)-1:0]   det_count,
  output logic [OUT_BITS-1:0]               sig_cut,
  output logic [OUT_BITS-1:0]               sig_ff
);

  localparam int CW = $clog2(NUM_FAULTS + 1);
  localparam int PW = $clog2(PAT_COUNT + 1);
  localparam logic [PW-1:0] PAT_LAST   = PW'(PAT_COUNT - 1);
  localparam logic [CW-1:0] FAULT_LAST = CW'(NUM_FAULTS - 1);
  localparam logic [CW-1:0] DET_MAX    = CW'(NUM_FAULTS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_CHECK = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [PW-1:0]       pat_cnt_q;
  logic                mismatch_q;
  logic                pat_ready_q, fil_inc_q, busy_q, done_q;
  logic                det_valid_q, det_flag_q;
  logic [CW-1:0]       fault_idx_q, det_count_q;
  logic [OUT_BITS-1:0] sig_cut_q, sig_ff_q;

  logic                xfer_d, last_xfer_d, mismatch_d, det_d;
  logic [OUT_BITS-1:0] misr_cut_d, misr_ff_d;

  function automatic logic [OUT_BITS-1:0] misr_step(input logic [OUT_BITS-1:0] m,
                                                    input logic [OUT_BITS-1:0] d);
    return {m[OUT_BITS-2:0], 1'b0} ^ (m[OUT_BITS-1] ? POLY : '0) ^ d;
  endfunction

  always_comb begin
    xfer_d     = pat_valid && pat_ready_q;
    misr_cut_d = misr_step(sig_cut_q, CUT_OP);
    misr_ff_d  = misr_step(sig_ff_q, FF_OP);
`ifdef RA_DIRECT_CMP_EN
    mismatch_d = mismatch_q | (CUT_OP != FF_OP);
`else
    mismatch_d = mismatch_q;
`endif
    // A direct mismatch closes the session early; otherwise only the count does.
    last_xfer_d = (pat_cnt_q == PAT_LAST) | mismatch_d;
    det_d       = (misr_cut_d != misr_ff_d) | mismatch_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pat_cnt_q   <= '0;
      mismatch_q  <= 1'b0;
      pat_ready_q <= 1'b0;
      fil_inc_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_valid_q <= 1'b0;
      det_flag_q  <= 1'b0;
      fault_idx_q <= '0;
      det_count_q <= '0;
      sig_cut_q   <= '0;
      sig_ff_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RUN;
            pat_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            pat_cnt_q   <= '0;
            mismatch_q  <= 1'b0;
            det_flag_q  <= 1'b0;
            fault_idx_q <= '0;
            det_count_q <= '0;
            sig_cut_q   <= '0;
            sig_ff_q    <= '0;
          end
        end
        S_RUN: begin
          if (xfer_d) begin
            sig_cut_q  <= misr_cut_d;
            sig_ff_q   <= misr_ff_d;
            pat_cnt_q  <= pat_cnt_q + PW'(1);
            mismatch_q <= mismatch_d;
            if (last_xfer_d) begin
              // Verdict is taken on the post-update signatures so it is valid in CHECK.
              state_q     <= S_CHECK;
              pat_ready_q <= 1'b0;
              det_valid_q <= 1'b1;
              det_flag_q  <= det_d;
              if (det_d && (det_count_q != DET_MAX))
                det_count_q <= det_count_q + CW'(1);
            end
          end
        end
        S_CHECK: begin
          det_valid_q <= 1'b0;
          if (fault_idx_q == FAULT_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_NEXT;
            fil_inc_q <= 1'b1;
          end
        end
        S_NEXT: begin
          state_q     <= S_RUN;
          fil_inc_q   <= 1'b0;
          pat_ready_q <= 1'b1;
          fault_idx_q <= fault_idx_q + CW'(1);
          pat_cnt_q   <= '0;
          mismatch_q  <= 1'b0;
          sig_cut_q   <= '0;
          sig_ff_q    <= '0;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pat_ready = pat_ready_q;
  assign FIL_INC   = fil_inc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign det_valid = det_valid_q;
  assign det_flag  = det_flag_q;
  assign fault_idx = fault_idx_q;
  assign det_count = det_count_q;
  assign sig_cut   = sig_cut_q;
  assign sig_ff    = sig_ff_q;

endmodule
`default_nettype wire

// File: doc/resp_analyzer.md
# resp_analyzer

Output response analyzer that sits directly downstream of the fault-injection mid section. Each cycle it consumes the faulty-CUT and fault-free-CUT output words and compresses both into parallel MISRs over a fixed-length pattern session per injected fault. At session end it compares the signatures, records detection, and pulses the fault-increment line back to the fault injection logic. It repeats this until every fault has been graded, then reports the detected-fault count.

## Interface
- OUT_BITS, 32, width of the CUT output words and of both MISRs
- PAT_COUNT, 256, patterns compressed per fault session (≥1)
- NUM_FAULTS, 64, number of fault sessions in one run (≥1)
- POLY, 32'h8020_0003, MISR feedback taps (low OUT_BITS bits used)
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a run; honoured only in IDLE
- pat_valid  in  1  CUT_OP/FF_OP carry a pattern response this cycle
- pat_ready  out  1  analyzer accepts a response; high only in RUN
- CUT_OP  in  OUT_BITS  faulty-CUT response
- FF_OP  in  OUT_BITS  fault-free-CUT response
- FIL_INC  out  1  one-cycle pulse: advance the fault injection logic to the next fault
- busy  out  1  high in RUN, CHECK and NEXT
- done  out  1  high in DONE
- det_valid  out  1  one-cycle pulse in CHECK
- det_flag  out  1  detection result of the session just checked, valid with det_valid
- fault_idx  out  $clog2(NUM_FAULTS+1)  index of the fault under test
- det_count  out  $clog2(NUM_FAULTS+1)  faults detected so far
- sig_cut, sig_ff  out  OUT_BITS  current MISR contents

## Operation
- States: IDLE, RUN, CHECK, NEXT, DONE.
- IDLE: start=1 → RUN. MISRs, pattern counter, fault_idx and det_count are cleared. Fault 0 is the fault already injected after the FIL reset.
- RUN: a transfer occurs when pat_valid && pat_ready. On each transfer, both MISRs update as m_next = {m[W-2:0],1'b0} ^ (m[W-1] ? POLY : 0) ^ data, with data=CUT_OP for sig_cut and data=FF_OP for sig_ff. The pattern counter also increments. When the transfer that makes the count PAT_COUNT occurs, the next state is CHECK.
- CHECK (1 cycle): det_flag = (sig_cut != sig_ff) | mismatch_seen. det_valid=1. det_count increments when det_flag=1; it saturates at NUM_FAULTS.
  - If fault_idx == NUM_FAULTS-1 → DONE. FIL_INC is not pulsed after the last fault.
  - Otherwise → NEXT.
- NEXT (1 cycle): FIL_INC=1. fault_idx increments. MISRs, pattern counter and mismatch_seen clear. Next state is RUN.
- DONE: done=1. All outputs hold. start is ignored. Only rst leaves DONE.
- pat_valid outside RUN is ignored; no MISR or counter change.
- CUT_OP/FF_OP are sampled only on transfer cycles.

## Timing
- Reset values (rst=0 at an edge): state IDLE; pat_ready, FIL_INC, busy, done, det_valid, det_flag = 0; fault_idx, det_count, sig_cut, sig_ff = 0.
- Reset asserted mid-run returns to IDLE on that edge. No FIL_INC is issued; the FIL must be reset alongside.
- start→pat_ready: 1 cycle.
- Last transfer→det_valid: 1 cycle.
- det_valid→FIL_INC: 1 cycle.
- FIL_INC→pat_ready: 1 cycle. The first post-increment response is accepted in the cycle after FIL_INC, so a fault-free session spans PAT_COUNT transfers plus 2 overhead cycles.
- All outputs are registered.

## Configuration
- RA_DIRECT_CMP_EN defined:
  - Each transfer also compares CUT_OP != FF_OP and sets sticky mismatch_seen.
  - A mismatching transfer ends the session early: the next state is CHECK regardless of the pattern count.
  - Detection is then immune to MISR aliasing.
- Undefined:
  - mismatch_seen is tied 0 and sessions always run PAT_COUNT transfers.
  - Detection is by signature only.

## Test plan
- PAT_COUNT=4, NUM_FAULTS=2, CUT_OP=FF_OP on every pattern, pat_valid held high → det_valid pulses twice with det_flag=0; exactly one FIL_INC between them; done=1 with det_count=0.
- Same, with CUT_OP=FF_OP^32'h1 on pattern 2 of fault 1 → det_flag=0 for fault 0 and 1 for fault 1; det_count=1.
  - With RA_DIRECT_CMP_EN: CHECK is entered the cycle after the third transfer.
- pat_valid toggling 1,0,1,0,… → only valid cycles count: MISR and counter change only on transfer cycles; CHECK is reached after 4 transfers.
- OUT_BITS=4, POLY=4'h9, single pattern FF_OP=4'h1 vs CUT_OP=4'h9 from zero seed → sig_ff=4'h1, sig_cut=4'h9, det_flag=1.
- rst=0 asserted two cycles into RUN → next cycle: state IDLE, all outputs 0; start then begins a fresh run at fault_idx 0.
- NUM_FAULTS=3, all faults detected → det_count=3, FIL_INC pulsed exactly 2 times; start while done=1 has no effect.
